// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
// fetch_queue
// Instruction fetch queue sitting between the PC register / instruction
// memory and decode. Each accepted fetch stores one {pc, instr} pair in a
// circular buffer of DEPTH entries. Decode drains the head in FIFO order.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge when the producer's valid and the
//   consumer's ready/accept are both high and flush is low. Upstream, the
//   accept is le_pc (= push). It is combinational from in_valid, the queue
//   level and flush, and it doubles as the PC register load enable. Downstream,
//   out_valid does not depend on out_ready. A full queue refuses a push even
//   when a pop happens in the same cycle.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   pc_in      PC of the word being fetched
//   instr_in   instruction memory read data for pc_in
//   in_valid   instr_in is valid this cycle
//   flush      discard all entries (branch/jump redirect), highest priority
//   le_pc      PC register load enable, high when the current fetch is accepted
//   out_valid  head entry valid
//   out_pc     PC of head entry (0 when empty)
//   out_instr  instruction of head entry (0 when empty)
//   out_ready  decode consumes the head this cycle
//   count      number of occupied entries, 0..DEPTH
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            pc_in,
  input  logic [DATA_W-1:0]            instr_in,
  input  logic                         in_valid,
  input  logic                         flush,
  output logic                         le_pc,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_pc,
  output logic [DATA_W-1:0]            out_instr,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 2 * DATA_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic [EW-1:0] head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = in_valid & ~full & ~flush;
  assign pop   = ~empty & out_ready & ~flush;
  assign head  = mem_q[rd_ptr_q];

  assign le_pc     = push;
  assign out_valid = ~empty;
  assign out_pc    = empty ? '0 : head[EW-1:DATA_W];
  assign out_instr = empty ? '0 : head[DATA_W-1:0];
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Stale storage contents are harmless: out_* are masked while empty.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {pc_in, instr_in};
        // DEPTH is a power of two, so the pointer wraps by plain overflow.
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] instr_in;
  logic              in_valid;
  logic              flush;
  logic              le_pc;
  logic              out_valid;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_instr;
  logic              out_ready;
  logic [CW-1:0]     count;

  fetch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .in_valid  (in_valid),
    .flush     (flush),
    .le_pc     (le_pc),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [2*DATA_W-1:0] exp_q[$];
  logic [2*DATA_W:0]   exp_head;
  logic [2*DATA_W:0]   obs_head;
  logic                exp_le;
  int                  n_checks;
  int                  n_fail;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] i,
                       input logic iv, input logic fl, input logic rdy);
    pc_in     = p;
    instr_in  = i;
    in_valid  = iv;
    flush     = fl;
    out_ready = rdy;
    #1;
    exp_le   = in_valid && (exp_q.size() < DEPTH) && !flush;
    exp_head = (exp_q.size() != 0) ? {1'b1, exp_q[0]} : '0;
    obs_head = {out_valid, out_pc, out_instr};
  endtask

  // Advance one clock edge and apply the expected effect to the scoreboard.
  task automatic tick();
    bit pm;
    bit qm;
    logic [2*DATA_W-1:0] d;
    pm = in_valid && (exp_q.size() < DEPTH) && !flush;
    qm = (exp_q.size() != 0) && out_ready && !flush;
    @(posedge clk);
    if (!reset || flush) begin
      exp_q.delete();
    end else begin
      if (qm) d = exp_q.pop_front();
      if (pm) exp_q.push_back({pc_in, instr_in});
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) reset = 1'b1;
      drive('0, '0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({obs_head, count, le_pc} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d: got valid=%b pc=%h instr=%h count=%0d le=%b, required all 0",
                 c, out_valid, out_pc, out_instr, count, le_pc);
      end
      tick();
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 6; k++) begin
      drive(DATA_W'(4 * k), DATA_W'(32'hA0 + k), 1'b1, 1'b0, 1'b0);
      if (k >= 4) begin
        // pc 16 presented while full: must stay refused
        drive(32'd16, 32'hA4, 1'b1, 1'b0, 1'b0);
      end
      n_checks++;
      if (le_pc !== exp_le) begin
        n_fail++;
        $display("FAIL fill_le k=%0d: got %b, required %b", k, le_pc, exp_le);
      end
      n_checks++;
      if (obs_head !== exp_head) begin
        n_fail++;
        $display("FAIL fill_head k=%0d: got %h, required %h", k, obs_head, exp_head);
      end
      n_checks++;
      if (count !== CW'(k > 4 ? 4 : k)) begin
        n_fail++;
        $display("FAIL fill_count k=%0d: got %0d, required %0d", k, count, (k > 4 ? 4 : k));
      end
      tick();
    end
    n_checks++;
    if (count !== CW'(4) || out_pc !== 32'd0 || out_instr !== 32'hA0) begin
      n_fail++;
      $display("FAIL fill_full: got count=%0d head=%h/%h, required 4 0/a0", count, out_pc, out_instr);
    end
  endtask

  task automatic test_full_drain();
    // pop + push attempt while full: push refused
    drive(32'd16, 32'hA4, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (le_pc !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_nobypass_le: got %b, required 0", le_pc);
    end
    tick();
    n_checks++;
    if (count !== CW'(3)) begin
      n_fail++;
      $display("FAIL drain_count3: got %0d, required 3", count);
    end
    drive(32'd16, 32'hA4, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (le_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_reaccept_le: got %b, required 1", le_pc);
    end
    tick();
    n_checks++;
    if (count !== CW'(4)) begin
      n_fail++;
      $display("FAIL drain_count4: got %0d, required 4", count);
    end
    for (int k = 0; k < 5; k++) begin
      drive('0, '0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (obs_head !== exp_head) begin
        n_fail++;
        $display("FAIL drain_order k=%0d: got %h, required %h", k, obs_head, exp_head);
      end
      n_checks++;
      if (k < 4 && out_pc !== DATA_W'(4 + 4 * k)) begin
        n_fail++;
        $display("FAIL drain_pc k=%0d: got %h, required %h", k, out_pc, 4 + 4 * k);
      end
      tick();
    end
  endtask

  task automatic test_stream_wrap();
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) drive(DATA_W'(32'h100 + 4 * k), DATA_W'($urandom), 1'b1, 1'b0, 1'b1);
      else        drive('0, '0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (le_pc !== exp_le || obs_head !== exp_head) begin
        n_fail++;
        $display("FAIL stream k=%0d: got le=%b head=%h, required le=%b head=%h",
                 k, le_pc, obs_head, exp_le, exp_head);
      end
      n_checks++;
      if (count > CW'(1) || count !== CW'(exp_q.size())) begin
        n_fail++;
        $display("FAIL stream_count k=%0d: got %0d, required %0d (max 1)", k, count, exp_q.size());
      end
      if (k > 0 && k < 10) begin
        n_checks++;
        if (out_pc !== DATA_W'(32'h100 + 4 * (k - 1))) begin
          n_fail++;
          $display("FAIL stream_pc k=%0d: got %h, required %h", k, out_pc, 32'h100 + 4 * (k - 1));
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive(DATA_W'(32'h180 + 4 * k), DATA_W'(32'hC0 + k), 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(32'h18C, 32'hC3, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (le_pc !== 1'b0 || count !== CW'(3)) begin
      n_fail++;
      $display("FAIL flush_cycle: got le=%b count=%0d, required le=0 count=3", le_pc, count);
    end
    tick();
    drive(32'h200, 32'hD0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (count !== CW'(0) || out_valid !== 1'b0 || le_pc !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_after: got count=%0d valid=%b le=%b, required 0 0 1", count, out_valid, le_pc);
    end
    tick();
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs_head !== {1'b1, 32'h200, 32'hD0} || count !== CW'(1) || obs_head !== exp_head) begin
      n_fail++;
      $display("FAIL flush_head: got %h count=%0d, required %h count=1", obs_head, count, exp_head);
    end
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_async_reset();
    drive(32'h300, 32'hE0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h304, 32'hE1, 1'b1, 1'b0, 1'b0);
    tick();
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (count !== CW'(2)) begin
      n_fail++;
      $display("FAIL areset_pre: got count=%0d, required 2", count);
    end
    #1 reset = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if ({out_valid, out_pc, out_instr, count} !== '0) begin
      n_fail++;
      $display("FAIL areset_immediate: got valid=%b pc=%h instr=%h count=%0d, required all 0",
               out_valid, out_pc, out_instr, count);
    end
    tick();
    reset = 1'b1;
    drive(32'h400, 32'hF0, 1'b1, 1'b0, 1'b0);
    tick();
    drive('0, '0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs_head !== exp_head || obs_head !== {1'b1, 32'h400, 32'hF0}) begin
      n_fail++;
      $display("FAIL areset_recover: got %h, required %h", obs_head, exp_head);
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      drive(DATA_W'($urandom), DATA_W'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
      n_checks++;
      if (le_pc !== exp_le || obs_head !== exp_head || count !== CW'(exp_q.size())) begin
        n_fail++;
        $display("FAIL random k=%0d: got le=%b head=%h count=%0d, required le=%b head=%h count=%0d",
                 k, le_pc, obs_head, count, exp_le, exp_head, exp_q.size());
      end
      tick();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    pc_in     = '0;
    instr_in  = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2;
    test_reset();
    test_fill();
    test_full_drain();
    test_stream_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the PC register / instruction memory and the decode stage. Each cycle it captures one {PC, instruction} pair and holds up to DEPTH entries. Decode drains the queue through a valid/ready handshake. The block drives the PC register's load enable, so the PC advances only when a fetched word is accepted. A flush discards every queued entry when a branch or jump redirects fetch.

## Interface
- DEPTH, 4, number of queue entries; power of two, ≥2
- DATA_W, 32, width of the PC and the instruction word
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset
- pc_in  input  DATA_W  PC of the word being fetched; taken from the PC register output
- instr_in  input  DATA_W  instruction memory read data for pc_in
- in_valid  input  1  instr_in is valid for pc_in this cycle
- flush  input  1  discard all entries; driven by branch resolution
- le_pc  output  1  load enable to the PC register; high when the current fetch is accepted
- out_valid  output  1  head entry is valid
- out_pc  output  DATA_W  PC of the head entry
- out_instr  output  DATA_W  instruction of the head entry
- out_ready  input  1  decode consumes the head this cycle; low while decode is stalled
- count  output  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Storage: circular buffer of DEPTH {pc, instr} entries.
  - Write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - Occupancy counter count, range 0..DEPTH.
- full = (count == DEPTH); empty = (count == 0).
- push = in_valid & ~full & ~flush.
  - On push, the entry at wr_ptr is written and wr_ptr increments.
- pop = out_valid & out_ready & ~flush.
  - On pop, rd_ptr increments.
- le_pc = push, combinational. The PC register advances exactly when a word is accepted.
- count update:
  - count + 1 on push only.
  - count − 1 on pop only.
  - Unchanged on push and pop together.
- Full queue: push is refused even if a pop occurs in the same cycle (no full-bypass), so le_pc = 0.
  - Decode draining one entry re-enables push on the following cycle.
- Empty queue: no pop is possible, and in_valid does not bypass to the output.
- Flush has priority over everything:
  - wr_ptr, rd_ptr and count clear to 0.
  - No push or pop occurs that cycle, and le_pc = 0 that cycle.
  - The PC register is loaded with the branch target by its own path, not through this block.
- out_valid = ~empty.
- out_pc and out_instr come combinationally from the entry at rd_ptr while out_valid = 1, and are forced to 0 while out_valid = 0.
- Entries leave in strict FIFO order; no reordering, no duplication.

## Timing
- Reset (reset = 0, asynchronous, effective immediately) clears wr_ptr, rd_ptr and count to 0 and all storage to 0.
  - Resulting outputs: out_valid = 0, out_pc = 0, out_instr = 0, count = 0, le_pc = 0.
  - Deassertion is sampled by clk; the first push can occur on the first rising edge after reset = 1.
- Latency: a word pushed at edge N is on out_* with out_valid = 1 after edge N (presentable to decode in cycle N+1).
- Throughput: one push and one pop per cycle sustained. With out_ready held high, count stays at 1 in steady state.
- Pop takes effect at the clock edge. The next entry, if any, appears on out_* right after that edge.
- Flush in cycle N: out_valid = 0 and count = 0 after edge N. in_valid in cycle N+1 is accepted normally.
- Reset asserted mid-operation aborts any push or pop in flight. No partial entry remains.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0 with no loss. Ordering is preserved across the wrap.

## Test plan
- Reset then idle:
  - Stimulus: hold reset = 0 for 3 cycles, release, in_valid = 0.
  - Response: out_valid = 0, out_pc = 0, out_instr = 0, count = 0, le_pc = 0 on every cycle.
- Fill to full:
  - Stimulus: out_ready = 0; push pc 0,4,8,12 with instr 0xA0..0xA3; then present pc 16.
  - Response: le_pc = 1 for four cycles; count = 4; on pc 16, le_pc = 0 and count stays 4.
  - Head reads pc 0 / 0xA0.
- Full drain with simultaneous push attempt:
  - Stimulus: from full, out_ready = 1 and in_valid = 1 with pc 16 for one cycle.
  - Response: pop of pc 0 occurs but push is refused, so count = 3; next cycle pc 16 is accepted and count = 4.
  - Output order is 4, 8, 12, 16.
- Streaming plus wrap:
  - Stimulus: out_ready = 1; 10 consecutive pushes, pc 0x100..0x124 in steps of 4.
  - Response: each pc appears on out_pc one cycle after its push, in order; count never exceeds 1; wrap occurs with no loss.
- Flush:
  - Stimulus: with 3 entries queued, assert flush together with in_valid = 1 and out_ready = 1.
  - Response: le_pc = 0 that cycle, no pop; next cycle count = 0 and out_valid = 0.
  - A following push of pc 0x200 appears alone at the head.
- Asynchronous reset mid-stream:
  - Stimulus: drop reset between clock edges while count = 2.
  - Response: out_valid, out_pc, out_instr and count go to 0 immediately, before the next edge.
